// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
// Holds the FSM state encoding and the one-hot grant decode used by the top.
package wb_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] grant_decode(input arb_state_e st);
    case (st)
      ST_GNT0: return 2'b01;
      ST_GNT1: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of a single pipelined slave.
// Tracks outstanding slave transfers so ownership is only released once all acks are back.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int MAXOUT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack,
  output logic          m1_stall,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack,
  input  logic          s_stall,
  output logic [1:0]    grant
);

  localparam int CW = $clog2(MAXOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXOUT);

  arb_state_e    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          ptr_r, ptr_nxt_s;   // last master granted; the other one wins a tie
  logic [1:0]    grant_r;
  logic          cnt_full_s, inc_s, dec_s;

  assign cnt_full_s = (cnt_r == CNT_MAX);
  assign inc_s      = s_stb & ~s_stall;
  assign dec_s      = s_ack & (cnt_r != {CW{1'b0}});
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign grant      = grant_r;

  // Next-state, pointer and bus-steering decode
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    s_cyc       = 1'b0;
    s_stb       = 1'b0;
    s_we        = 1'b0;
    s_adr       = {AW{1'b0}};
    s_dat_o     = {DW{1'b0}};
    m0_stall    = 1'b1;
    m1_stall    = 1'b1;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_nxt_s = ptr_r ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc) begin
          state_nxt_s = ST_GNT0;
        end else if (m1_cyc) begin
          state_nxt_s = ST_GNT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb & m0_cyc & ~cnt_full_s;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_o  = m0_dat_i;
        m0_stall = s_stall | cnt_full_s;
        m0_ack   = s_ack & m0_cyc;
        // Hold ownership until every issued transfer has been acknowledged
        if (!m0_cyc && (cnt_r == {CW{1'b0}})) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_GNT0;
        end
      end
      ST_GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb & m1_cyc & ~cnt_full_s;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_o  = m1_dat_i;
        m1_stall = s_stall | cnt_full_s;
        m1_ack   = s_ack & m1_cyc;
        if (!m1_cyc && (cnt_r == {CW{1'b0}})) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_GNT1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Outstanding-transfer counter; issue and ack in one cycle cancel out
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (inc_s && !dec_s) begin
      cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else if (dec_s && !inc_s) begin
      cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, counter, pointer and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      ptr_r   <= 1'b1;
      grant_r <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
      grant_r <= grant_decode(state_nxt_s);
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2 with a behavioural pipelined RAM slave.
// Expected read data and acks are queued per master when a strobe is accepted.
module tb_wb_arbiter2;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAXOUT = 2;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mc [2];
  logic          ms [2];
  logic          mw [2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] md [2];
  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_ack, m0_stall, m1_ack, m1_stall;
  logic          s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [AW-1:0] s_adr;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(mc[0]), .m0_stb(ms[0]), .m0_we(mw[0]), .m0_adr(ma[0]), .m0_dat_i(md[0]),
    .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_cyc(mc[1]), .m1_stb(ms[1]), .m1_we(mw[1]), .m1_adr(ma[1]), .m1_dat_i(md[1]),
    .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_stall(s_stall), .grant(grant)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 16'h3C00 ^ a;
  endfunction

  // RAM slave with a fixed ack latency of lat cycles; not reset, so in-flight acks survive rst_n
  int            lat = 1;
  logic [DW-1:0] ram [256];
  logic          wr_vld [256] = '{default: 1'b0};
  logic          vld [4] = '{default: 1'b0};
  logic [DW-1:0] pdat [4];

  assign s_stall = 1'b0;
  assign s_ack   = vld[lat-1];
  assign s_dat_i = pdat[lat-1];

  always @(posedge clk) begin
    vld[0]  <= s_cyc & s_stb & ~s_stall;
    pdat[0] <= wr_vld[s_adr[7:0]] ? ram[s_adr[7:0]] : pat(s_adr);
    if (s_cyc && s_stb && !s_stall && s_we) begin
      ram[s_adr[7:0]]    <= s_dat_o;
      wr_vld[s_adr[7:0]] <= 1'b1;
    end
    for (int i = 1; i < 4; i++) begin
      vld[i]  <= vld[i-1];
      pdat[i] <= pdat[i-1];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic int sb_size(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void sb_flush(input int m);
    if (m == 0) q0.delete(); else q1.delete();
  endfunction

  int cyc_n = 0;
  int acc_cnt [2], acc3_cyc [2], first_ack_cyc [2], last_ack_cyc [2], ack_run [2], max_run [2];
  int s_ack_cnt = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic clear_stats();
    for (int m = 0; m < 2; m++) begin
      acc_cnt[m] = 0; acc3_cyc[m] = -1; first_ack_cyc[m] = -1;
      last_ack_cyc[m] = -10; ack_run[m] = 0; max_run[m] = 0;
    end
  endtask

  // Monitor: pops on ack, pushes on accepted strobe, checks the losing master is blocked
  always @(negedge clk) begin
    logic ack, stall;
    logic [DW-1:0] dat;
    exp_t e;
    if (s_ack) s_ack_cnt++;
    for (int m = 0; m < 2; m++) begin
      ack   = (m == 0) ? m0_ack : m1_ack;
      stall = (m == 0) ? m0_stall : m1_stall;
      dat   = (m == 0) ? m0_dat_o : m1_dat_o;
      if (ack) begin
        ack_run[m] = (last_ack_cyc[m] == cyc_n - 1) ? ack_run[m] + 1 : 1;
        last_ack_cyc[m] = cyc_n;
        if (ack_run[m] > max_run[m]) max_run[m] = ack_run[m];
        if (first_ack_cyc[m] < 0) first_ack_cyc[m] = cyc_n;
        if (sb_size(m) == 0) begin
          check((m == 0) ? "m0_unexpected_ack" : "m1_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = (m == 0) ? q0.pop_front() : q1.pop_front();
          if (!e.we) check((m == 0) ? "m0_rd_data" : "m1_rd_data", 32'(dat), 32'(e.d));
        end
      end
      if (mc[m] && ms[m] && !stall) begin
        if (mw[m]) begin
          ref_mem[ma[m]] = md[m];
          e = '{we: 1'b1, d: md[m]};
        end else begin
          e = '{we: 1'b0, d: ref_mem.exists(ma[m]) ? ref_mem[ma[m]] : pat(ma[m])};
        end
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        acc_cnt[m]++;
        if (acc_cnt[m] == 3) acc3_cyc[m] = cyc_n;
        check("outstanding_le_max", 32'(sb_size(m) <= MAXOUT), 32'd1);
      end
    end
    if (grant == 2'b01 && mc[1]) check("m1_blocked", 32'({m1_stall, m1_ack}), 32'b10);
    if (grant == 2'b10 && mc[0]) check("m0_blocked", 32'({m0_stall, m0_ack}), 32'b10);
    if (grant != 2'b00) check("cnt_bound", 32'(dut.cnt_r <= MAXOUT), 32'd1);
  end

  logic [AW-1:0] xa [4];
  logic [DW-1:0] xd [4];

  task automatic master_xfer(input int m, input logic we, input int n);
    logic acc;
    int g;
    mc[m] = 1'b1;
    for (int i = 0; i < n; i++) begin
      mw[m] = we; ma[m] = xa[i]; md[m] = xd[i]; ms[m] = 1'b1;
      g = 0;
      do begin
        @(negedge clk);
        acc = ~((m == 0) ? m0_stall : m1_stall);
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 50);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
    ms[m] = 1'b0;
  endtask

  task automatic wait_drain(input int m);
    int g = 0;
    while (sb_size(m) != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", 32'(sb_size(m)), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'b00);
    check({tag, "_stalls"}, 32'({m0_stall, m1_stall}), 32'b11);
    check({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'b00);
    check({tag, "_s_cyc_stb"}, 32'({s_cyc, s_stb}), 32'b00);
    check({tag, "_cnt"}, 32'(dut.cnt_r), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic idle_seen;
    int g, ack_before;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0; ma[m] = '0; md[m] = '0;
    end
    clear_stats();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // m0 alone: three pipelined reads with back-to-back acks
    clear_stats();
    xa[0] = 16'h10; xa[1] = 16'h11; xa[2] = 16'h12;
    master_xfer(0, 1'b0, 3);
    check("t1_grant", 32'(grant), 32'b01);
    wait_drain(0);
    check("t1_ack_run", 32'(max_run[0]), 32'd3);
    check("t1_cnt_zero", 32'(dut.cnt_r), 32'd0);
    mc[0] = 1'b0;
    @(posedge clk); #1;
    check("t1_grant_idle", 32'(grant), 32'b00);

    // Reset again so the tie below sees the reset pointer
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst2_grant", 32'(grant), 32'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous request: m0 first, m1 waits through two writes, then reads them back
    mc[0] = 1'b1; mc[1] = 1'b1;
    @(posedge clk); #1;
    check("tie_grant_m0", 32'(grant), 32'b01);
    xa[0] = 16'h0005; xd[0] = 16'hA5A5; xa[1] = 16'h0006; xd[1] = 16'h5A5A;
    master_xfer(0, 1'b1, 2);
    wait_drain(0);
    mc[0] = 1'b0;
    @(posedge clk); #1;
    check("handover_idle", 32'(grant), 32'b00);
    @(posedge clk); #1;
    check("handover_grant_m1", 32'(grant), 32'b10);
    xd[0] = '0; xd[1] = '0;
    master_xfer(1, 1'b0, 2);
    wait_drain(1);
    check("t3_ref_a5a5", 32'(ref_mem[16'h0005]), 32'h0000A5A5);
    mc[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Slow slave: third strobe must wait for the first ack
    lat = 3;
    clear_stats();
    xa[0] = 16'h20; xa[1] = 16'h21; xa[2] = 16'h22;
    master_xfer(0, 1'b0, 3);
    wait_drain(0);
    check("t4_third_after_ack", 32'(acc3_cyc[0]), 32'(first_ack_cyc[0] + 1));
    mc[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // m0 abandons a read with one outstanding; late ack must be swallowed
    clear_stats();
    xa[0] = 16'h30;
    master_xfer(0, 1'b0, 1);
    mc[0] = 1'b0;
    sb_flush(0);
    mc[1] = 1'b1;
    ack_before = s_ack_cnt;
    #1;
    check("t5_s_cyc_drop", 32'(s_cyc), 32'd0);
    check("t5_still_gnt0", 32'(grant), 32'b01);
    idle_seen = 1'b0;
    g = 0;
    while (grant != 2'b10 && g < 20) begin
      @(posedge clk); #1;
      if (grant == 2'b00) idle_seen = 1'b1;
      g++;
    end
    check("t5_idle_between", 32'(idle_seen), 32'd1);
    check("t5_m1_granted", 32'(grant), 32'b10);
    check("t5_late_ack_seen", 32'(s_ack_cnt > ack_before), 32'd1);
    xa[0] = 16'h31;
    master_xfer(1, 1'b0, 1);
    wait_drain(1);
    mc[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset mid-transfer in GNT1; stray ack after release must not move cnt
    xa[0] = 16'h40;
    master_xfer(1, 1'b0, 1);
    check("t6_grant_m1", 32'(grant), 32'b10);
    check("t6_cnt_one", 32'(dut.cnt_r), 32'd1);
    #1 rst_n = 1'b0;
    mc[1] = 1'b0;
    sb_flush(1);
    #1 check_reset_outputs("async_rst");
    #8 rst_n = 1'b1;
    ack_before = s_ack_cnt;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t6_cnt_stays_zero", 32'(dut.cnt_r), 32'd0);
    end
    check("t6_stray_ack_seen", 32'(s_ack_cnt > ack_before), 32'd1);
    check("t6_grant_idle", 32'(grant), 32'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
